// File: rtl/bus_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory port.
// slave  : the arbiter's view (requests in, completions out, drives memory side).
// master : the environment's view (requesters and memory model).
interface bus_arbiter_if;
  logic        req0_valid;
  logic [31:0] req0_address;
  logic [3:0]  req0_wstrobe;
  logic [31:0] req0_wdata;
  logic        req0_ready;
  logic [31:0] req0_rdata;

  logic        req1_valid;
  logic [31:0] req1_address;
  logic [3:0]  req1_wstrobe;
  logic [31:0] req1_wdata;
  logic        req1_ready;
  logic [31:0] req1_rdata;

  logic        mem_valid;
  logic [31:0] mem_address;
  logic [3:0]  mem_wstrobe;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  req0_valid, req0_address, req0_wstrobe, req0_wdata,
    input  req1_valid, req1_address, req1_wstrobe, req1_wdata,
    input  mem_ready, mem_rdata,
    output req0_ready, req0_rdata, req1_ready, req1_rdata,
    output mem_valid, mem_address, mem_wstrobe, mem_wdata
  );

  modport master (
    output req0_valid, req0_address, req0_wstrobe, req0_wdata,
    output req1_valid, req1_address, req1_wstrobe, req1_wdata,
    output mem_ready, mem_rdata,
    input  req0_ready, req0_rdata, req1_ready, req1_rdata,
    input  mem_valid, mem_address, mem_wstrobe, mem_wdata
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory port.
// A grant is registered and held until the memory completes the transfer;
// all bus outputs are muxed from the registered state only.
// Optional feature: define BUS_ARB_TIMEOUT_EN to abort a granted transfer
// that waits TIMEOUT_CYCLES cycles for mem_ready (returns ERROR_WORD and
// pulses timeout_err). Without it timeout_err is tied 0.
module bus_arbiter #(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERROR_WORD     = 32'hDEAD_BEEF
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus,
  output logic [1:0]    grant,
  output logic          timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  // last_q = 1 lets requester 0 win the next tie, 0 lets requester 1 win.
  logic   last_q, last_d;
  logic   tmo_hit;
  logic   done;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  // A stalled grant expires on its TIMEOUT_CYCLES-th cycle unless mem_ready wins that cycle.
  assign tmo_hit = (state_q != IDLE) && !bus.mem_ready &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait counter: cleared on every state change, counts stalled grant cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else if (state_d != state_q)
      cnt_q <= '0;
    else if ((state_q != IDLE) && !bus.mem_ready)
      cnt_q <= cnt_q + CNT_W'(1);
  end
`else
  assign tmo_hit = 1'b0;
  logic unused_cfg;
  assign unused_cfg = ERROR_WORD[0] ^ (TIMEOUT_CYCLES != 0);
`endif

  // A granted transfer ends on a memory completion or an expired wait.
  assign done = bus.mem_ready || tmo_hit;

  // State and priority pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next-state: round-robin on ties, direct hand-over when the other side waits.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (bus.req0_valid && bus.req1_valid)
          state_d = last_q ? GRANT0 : GRANT1;
        else if (bus.req0_valid)
          state_d = GRANT0;
        else if (bus.req1_valid)
          state_d = GRANT1;
      end
      GRANT0: begin
        if (done) begin
          last_d  = 1'b0;
          state_d = bus.req1_valid ? GRANT1 : IDLE;
        end else if (!bus.req0_valid) begin
          state_d = IDLE;
        end
      end
      GRANT1: begin
        if (done) begin
          last_d  = 1'b1;
          state_d = bus.req0_valid ? GRANT0 : IDLE;
        end else if (!bus.req1_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output mux: owner's fields go to memory, memory response goes to owner only.
  always_comb begin
    grant            = 2'b00;
    timeout_err      = 1'b0;
    bus.mem_valid    = 1'b0;
    bus.mem_address  = '0;
    bus.mem_wstrobe  = '0;
    bus.mem_wdata    = '0;
    bus.req0_ready   = 1'b0;
    bus.req0_rdata   = '0;
    bus.req1_ready   = 1'b0;
    bus.req1_rdata   = '0;
    case (state_q)
      GRANT0: begin
        grant           = 2'b01;
        bus.mem_valid   = bus.req0_valid;
        bus.mem_address = bus.req0_address;
        bus.mem_wstrobe = bus.req0_wstrobe;
        bus.mem_wdata   = bus.req0_wdata;
        bus.req0_ready  = bus.mem_ready;
        bus.req0_rdata  = bus.mem_rdata;
`ifdef BUS_ARB_TIMEOUT_EN
        if (tmo_hit) begin
          bus.req0_ready = 1'b1;
          bus.req0_rdata = ERROR_WORD;
          timeout_err    = 1'b1;
        end
`endif
      end
      GRANT1: begin
        grant           = 2'b10;
        bus.mem_valid   = bus.req1_valid;
        bus.mem_address = bus.req1_address;
        bus.mem_wstrobe = bus.req1_wstrobe;
        bus.mem_wdata   = bus.req1_wdata;
        bus.req1_ready  = bus.mem_ready;
        bus.req1_rdata  = bus.mem_rdata;
`ifdef BUS_ARB_TIMEOUT_EN
        if (tmo_hit) begin
          bus.req1_ready = 1'b1;
          bus.req1_rdata = ERROR_WORD;
          timeout_err    = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: stimulus pushes expected completions and
// memory handshakes into queues; a negedge monitor pops and compares them.
module tb_bus_arbiter;
  localparam int TMO = 8;

  logic       clk;
  logic       reset;
  logic [1:0] grant;
  logic       timeout_err;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  bus_arbiter_if bus();

  bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .grant(grant),
    .timeout_err(timeout_err)
  );

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        terr;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [1:0]  gnt;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    int          cyc;
  } mem_t;

  rsp_t rsp_q[$];
  mem_t mem_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_address = '0; bus.req0_wstrobe = '0; bus.req0_wdata = '0;
    bus.req1_valid = 1'b0; bus.req1_address = '0; bus.req1_wstrobe = '0; bus.req1_wdata = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic exp_rsp(input int port, input logic [31:0] rd, input logic te, input int c);
    rsp_t r;
    r.port = port; r.rdata = rd; r.terr = te; r.cyc = c;
    rsp_q.push_back(r);
  endtask

  task automatic exp_mem(input logic [1:0] g, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input int c);
    mem_t m;
    m.gnt = g; m.addr = a; m.strb = s; m.wdata = d; m.cyc = c;
    mem_q.push_back(m);
  endtask

  // Monitor: every completion / memory handshake must match the next expectation.
  always @(negedge clk) begin
    rsp_t e;
    mem_t m;
    if (bus.req0_ready || bus.req1_ready || timeout_err) begin
      if (rsp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rsp: ready=%b%b terr=%b at cycle %0d, expected no response",
                 bus.req1_ready, bus.req0_ready, timeout_err, cyc);
      end else begin
        e = rsp_q.pop_front();
        chk("rsp_ready", 32'({bus.req1_ready, bus.req0_ready}), (e.port == 0) ? 32'd1 : 32'd2);
        chk("rsp_rdata", bus.req1_ready ? bus.req1_rdata : bus.req0_rdata, e.rdata);
        chk("rsp_terr", 32'(timeout_err), 32'(e.terr));
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
    if (bus.mem_valid && bus.mem_ready) begin
      if (mem_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_mem: addr=%h at cycle %0d, expected no handshake",
                 bus.mem_address, cyc);
      end else begin
        m = mem_q.pop_front();
        chk("mem_grant", 32'(grant), 32'(m.gnt));
        chk("mem_addr", bus.mem_address, m.addr);
        chk("mem_strb", 32'(bus.mem_wstrobe), 32'(m.strb));
        chk("mem_wdata", bus.mem_wdata, m.wdata);
        chk("mem_cycle", cyc, m.cyc);
      end
    end
  end

  initial begin
    int t0;
    reset = 1'b1;
    idle_inputs();
    step();
    // Reset state, with request and memory inputs active
    bus.req0_valid = 1'b1; bus.req0_address = 32'h0000_0ABC;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    step();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst_mem_addr", bus.mem_address, 32'd0);
    chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    chk("rst_req0_rdata", bus.req0_rdata, 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    idle_inputs();
    step();
    reset = 1'b0;
    step();

    // Test 1: req0 read, memory ready after 2 wait cycles
    t0 = cyc;
    bus.req0_valid = 1'b1; bus.req0_address = 32'h0000_0100;
    exp_rsp(0, 32'h1234_5678, 1'b0, t0 + 3);
    exp_mem(2'b01, 32'h0000_0100, 4'h0, 32'h0, t0 + 3);
    #1;
    chk("t1_grant_c0", 32'(grant), 32'd0);
    chk("t1_mem_valid_c0", 32'(bus.mem_valid), 32'd0);
    step();
    chk("t1_grant_c1", 32'(grant), 32'd1);
    chk("t1_mem_valid_c1", 32'(bus.mem_valid), 32'd1);
    chk("t1_addr_c1", bus.mem_address, 32'h0000_0100);
    step();
    chk("t1_addr_c2", bus.mem_address, 32'h0000_0100);
    chk("t1_ready_c2", 32'(bus.req0_ready), 32'd0);
    step();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1234_5678;
    #1;
    chk("t1_addr_c3", bus.mem_address, 32'h0000_0100);
    step();
    idle_inputs();
    #1;
    chk("t1_idle_c4", 32'(grant), 32'd0);

    // Test 2: tie after reset, hand-over without bubble, back-to-back bubble, tie with last=0
    do_reset();
    t0 = cyc;
    bus.req0_valid = 1'b1; bus.req0_address = 32'h0000_0300;
    bus.req1_valid = 1'b1; bus.req1_address = 32'h0000_0400;
    step();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1111_1111;
    exp_rsp(0, 32'h1111_1111, 1'b0, t0 + 1);
    exp_mem(2'b01, 32'h0000_0300, 4'h0, 32'h0, t0 + 1);
    #1;
    chk("t2_req0_first", 32'(grant), 32'd1);
    step();
    bus.req0_address = 32'h0000_0304; bus.mem_rdata = 32'h2222_2222;
    exp_rsp(1, 32'h2222_2222, 1'b0, t0 + 2);
    exp_mem(2'b10, 32'h0000_0400, 4'h0, 32'h0, t0 + 2);
    #1;
    chk("t2_no_bubble", 32'(grant), 32'd2);
    step();
    bus.req1_valid = 1'b0; bus.mem_rdata = 32'h3333_3333;
    exp_rsp(0, 32'h3333_3333, 1'b0, t0 + 3);
    exp_mem(2'b01, 32'h0000_0304, 4'h0, 32'h0, t0 + 3);
    #1;
    chk("t2_req0_after_req1", 32'(grant), 32'd1);
    step();
    bus.mem_ready = 1'b0; bus.req0_address = 32'h0000_0308;
    bus.req1_valid = 1'b1; bus.req1_address = 32'h0000_0404;
    #1;
    chk("t2_b2b_bubble", 32'(grant), 32'd0);
    step();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h4444_4444;
    exp_rsp(1, 32'h4444_4444, 1'b0, t0 + 5);
    exp_mem(2'b10, 32'h0000_0404, 4'h0, 32'h0, t0 + 5);
    #1;
    chk("t2_tie_last0", 32'(grant), 32'd2);
    step();
    bus.req1_valid = 1'b0; bus.mem_rdata = 32'h5555_5555;
    exp_rsp(0, 32'h5555_5555, 1'b0, t0 + 6);
    exp_mem(2'b01, 32'h0000_0308, 4'h0, 32'h0, t0 + 6);
    #1;
    chk("t2_handover_req0", 32'(grant), 32'd1);
    step();
    idle_inputs();
    #1;
    chk("t2_idle_end", 32'(grant), 32'd0);

    // Test 3: requester 1 write
    t0 = cyc;
    bus.req1_valid = 1'b1; bus.req1_address = 32'h0000_0200;
    bus.req1_wstrobe = 4'b0011; bus.req1_wdata = 32'hAABB_CCDD;
    exp_rsp(1, 32'h0BAD_0001, 1'b0, t0 + 3);
    exp_mem(2'b10, 32'h0000_0200, 4'b0011, 32'hAABB_CCDD, t0 + 3);
    step();
    chk("t3_grant", 32'(grant), 32'd2);
    chk("t3_wstrobe", 32'(bus.mem_wstrobe), 32'd3);
    chk("t3_wdata", bus.mem_wdata, 32'hAABB_CCDD);
    chk("t3_req0_ready_c1", 32'(bus.req0_ready), 32'd0);
    step();
    chk("t3_req0_ready_c2", 32'(bus.req0_ready), 32'd0);
    step();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0BAD_0001;
    #1;
    chk("t3_req0_ready_c3", 32'(bus.req0_ready), 32'd0);
    chk("t3_req0_rdata_c3", bus.req0_rdata, 32'd0);
    step();
    idle_inputs();
    #1;
    chk("t3_idle", 32'(grant), 32'd0);

    // Protocol violation: req0 drops valid while granted; pointer must stay at 1
    t0 = cyc;
    bus.req0_valid = 1'b1; bus.req0_address = 32'h0000_0500;
    step();
    chk("pv_grant", 32'(grant), 32'd1);
    bus.req0_valid = 1'b0;
    step();
    chk("pv_idle", 32'(grant), 32'd0);
    bus.req0_valid = 1'b1; bus.req0_address = 32'h0000_0600;
    bus.req1_valid = 1'b1; bus.req1_address = 32'h0000_0700;
    step();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h6666_6666;
    exp_rsp(0, 32'h6666_6666, 1'b0, t0 + 3);
    exp_mem(2'b01, 32'h0000_0600, 4'h0, 32'h0, t0 + 3);
    #1;
    chk("pv_last_unchanged", 32'(grant), 32'd1);
    step();
    bus.req0_valid = 1'b0; bus.mem_rdata = 32'h7777_7777;
    exp_rsp(1, 32'h7777_7777, 1'b0, t0 + 4);
    exp_mem(2'b10, 32'h0000_0700, 4'h0, 32'h0, t0 + 4);
    #1;
    chk("pv_req1_next", 32'(grant), 32'd2);
    step();
    idle_inputs();
    #1;
    chk("pv_idle_end", 32'(grant), 32'd0);

    // Test 4: asynchronous reset in the middle of a GRANT1 cycle
    bus.req1_valid = 1'b1; bus.req1_address = 32'h0000_0800;
    step();
    chk("t4_grant_before", 32'(grant), 32'd2);
    #1;
    reset = 1'b1; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h9999_9999;
    #1;
    chk("t4_async_grant", 32'(grant), 32'd0);
    chk("t4_async_mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("t4_async_addr", bus.mem_address, 32'd0);
    chk("t4_no_req1_ready", 32'(bus.req1_ready), 32'd0);
    step();
    idle_inputs();
    reset = 1'b0;
    step();
    chk("t4_idle_after", 32'(grant), 32'd0);

`ifdef BUS_ARB_TIMEOUT_EN
    // Timeout with memory never ready
    t0 = cyc;
    bus.req0_valid = 1'b1; bus.req0_address = 32'h0000_0900;
    exp_rsp(0, 32'hDEAD_BEEF, 1'b1, t0 + TMO);
    for (int i = 1; i < TMO; i++) begin
      step();
      chk("tmo_hold_grant", 32'(grant), 32'd1);
      chk("tmo_no_err_yet", 32'(timeout_err), 32'd0);
    end
    step();
    step();
    idle_inputs();
    #1;
    chk("tmo_released", 32'(grant), 32'd0);
    chk("tmo_err_pulse", 32'(timeout_err), 32'd0);

    // mem_ready exactly on the last cycle wins over the timeout
    t0 = cyc;
    bus.req0_valid = 1'b1; bus.req0_address = 32'h0000_0A00;
    exp_rsp(0, 32'h5A5A_5A5A, 1'b0, t0 + TMO);
    exp_mem(2'b01, 32'h0000_0A00, 4'h0, 32'h0, t0 + TMO);
    for (int i = 1; i < TMO; i++) step();
    step();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h5A5A_5A5A;
    step();
    idle_inputs();
    #1;
    chk("tmo_race_idle", 32'(grant), 32'd0);
`else
    // Without the timeout a stalled grant is held indefinitely
    t0 = cyc;
    bus.req0_valid = 1'b1; bus.req0_address = 32'h0000_0900;
    for (int i = 1; i <= TMO + 4; i++) begin
      step();
      chk("notmo_hold_grant", 32'(grant), 32'd1);
      chk("notmo_terr", 32'(timeout_err), 32'd0);
    end
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h5A5A_5A5A;
    exp_rsp(0, 32'h5A5A_5A5A, 1'b0, t0 + TMO + 4);
    exp_mem(2'b01, 32'h0000_0900, 4'h0, 32'h0, t0 + TMO + 4);
    step();
    idle_inputs();
    #1;
    chk("notmo_idle", 32'(grant), 32'd0);
`endif

    step();
    step();
    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    chk("mem_queue_drained", 32'(mem_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-requester arbiter sharing one memory bus port: requester 0 (CPU core) and requester 1 (DMA or debug master).
- Requester and memory sides use the same valid/ready request protocol as the core bus, with 32-bit address/data and 4-bit write strobes.
- Arbitration is round-robin. A grant is registered and held until the memory completes the transfer.
- Sits between the masters and the memory/interconnect.

Parameters:
- TIMEOUT_CYCLES, 256: maximum cycles a granted transfer may wait for mem_ready. Used only with the optional feature.
- ERROR_WORD, 32'hDEAD_BEEF: rdata returned on a timed-out transfer. Used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 transfer request
- req0_address  in  32  requester 0 byte address
- req0_wstrobe  in  4  requester 0 byte write enables (0 = read)
- req0_wdata  in  32  requester 0 write data
- req0_ready  out  1  requester 0 transfer complete
- req0_rdata  out  32  requester 0 read data
- req1_valid, req1_address, req1_wstrobe, req1_wdata, req1_ready, req1_rdata: same as requester 0, for requester 1
- mem_valid  out  1  memory request
- mem_address  out  32  memory address
- mem_wstrobe  out  4  memory write strobes
- mem_wdata  out  32  memory write data
- mem_ready  in  1  memory transfer complete
- mem_rdata  in  32  memory read data
- grant  out  2  one-hot current owner (00 = idle)
- timeout_err  out  1  one-cycle pulse on timeout (optional feature only; tied 0 otherwise)

Behaviour:
- State register: IDLE, GRANT0, GRANT1. Priority pointer `last`: 0 means requester 1 wins a tie; 1 means requester 0 wins a tie.
- Reset (asynchronous, active-high): state = IDLE, last = 1 (requester 0 wins first tie), timeout counter = 0.
- Output values during reset: grant = 00, mem_valid = 0, mem_address/mem_wstrobe/mem_wdata = 0, req*_ready = 0, req*_rdata = 0, timeout_err = 0.
- IDLE:
  - Only req0_valid → GRANT0 next cycle.
  - Only req1_valid → GRANT1 next cycle.
  - Both → the requester not equal to `last`.
  - Neither → stay IDLE.
  - Arbitration latency is one cycle: a requester valid at cycle N sees mem_valid at N+1 at the earliest.
- GRANTk:
  - mem_valid = reqk_valid; mem_address/mem_wstrobe/mem_wdata = reqk fields; grant bit k = 1.
  - reqk_ready = mem_ready; reqk_rdata = mem_rdata (combinational pass-through).
  - The other requester's ready = 0 and rdata = 0.
  - Outputs are muxed from the registered state only, never from same-cycle arbitration.
- On mem_ready in GRANTk:
  - last ← k.
  - If the other requester's valid is high → GRANT(other) directly, with no idle bubble.
  - Else if reqk_valid is still high (back-to-back by the same master) → IDLE. This forces a re-arbitration cycle.
  - Else → IDLE.
- Requesters hold valid and their fields stable until ready; the arbiter does not register request fields.
- If reqk_valid drops while granted without ready (protocol violation) → IDLE next cycle, last unchanged, no memory access is completed.
- mem_valid is 0 in IDLE. Outside GRANTk, the mem_address/mem_wstrobe/mem_wdata outputs are 0.
- Reset asserted mid-transfer: immediate return to IDLE. The in-flight transfer is abandoned, with no ready to either requester.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering GRANTk and increments each GRANTk cycle without mem_ready.
  - When the counter reaches TIMEOUT_CYCLES-1 with no mem_ready, the arbiter asserts for that one cycle: reqk_ready = 1, reqk_rdata = ERROR_WORD, timeout_err = 1.
  - The state then leaves GRANTk by the same rules as a normal completion.
  - A mem_ready in the same cycle takes precedence (normal completion, no error).
- Undefined: no counter, timeout_err tied 0, a grant waits indefinitely.

Test Plan:
- Reset, then req0 read of 0x0000_0100 with memory ready after 2 cycles, rdata 0x1234_5678 → grant = 01 on cycle 1; mem_address = 0x100 on cycles 1-3; req0_ready and req0_rdata = 0x1234_5678 on cycle 3; back to IDLE on cycle 4.
- Both requesters valid in IDLE after reset → requester 0 granted first. On its ready, requester 1 is granted the next cycle with no IDLE cycle. On requester 1's ready, a still-pending req0 wins the next tie.
- Requester 1 write of 0x0000_0200, wstrobe 4'b0011, wdata 0xAABB_CCDD → mem_wstrobe = 0011 and mem_wdata = 0xAABB_CCDD during grant; req0_ready stays 0 throughout.
- Assert reset asynchronously mid-GRANT1 (between clock edges) → grant = 00 and mem_valid = 0 immediately; no ready ever reaches requester 1.
- With BUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, mem_ready held 0 → on the 8th GRANT0 cycle: req0_ready = 1, req0_rdata = 0xDEAD_BEEF, timeout_err pulses one cycle; grant releases on the next cycle.
- Same timeout setup with mem_ready arriving exactly on the 8th cycle → normal completion with mem_rdata returned; timeout_err stays 0.
